uart_apb_sequencer: RTL and testbench

APB3 master controller that owns the register port of a 16550-style UART. After reset it runs a fixed initialisation sequence: divisor latch, line control and FIFO control. It then arbitrates the single APB3 port between a host register-access port and a TX byte stream. For the TX stream it polls LSR.THRE and writes THR when the holding register is empty.

---
 rtl/uart_apb_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB3 master that initialises a 16550 UART, then shares its register port between a host and a TX byte stream.
// Latency: every transfer is SETUP + ACCESS (>=1 cycle) + 1 idle cycle; host_rsp_valid/tx_ready/init_done rise the cycle after ACCESS completes.
// Backpressure: host_req_ready/tx_ready stay low until init completes; pready stretches ACCESS, bounded by TimeoutCycles only when UART_SEQ_TIMEOUT_EN is defined.
module uart_apb_sequencer #(
  parameter int unsigned             AddressWidth  = 32,
  parameter int unsigned             DataWidth     = 32,
  parameter logic [AddressWidth-1:0] BaseAddr      = '0,
  parameter int unsigned             RegStride     = 4,
  parameter logic [15:0]             Divisor       = 16'd10,
  parameter logic [7:0]              LcrValue      = 8'h03,
  parameter int unsigned             TimeoutCycles = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [AddressWidth-1:0] paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic                    host_req_valid,
  output logic                    host_req_ready,
  input  logic                    host_req_write,
  input  logic [2:0]              host_req_reg,
  input  logic [7:0]              host_req_wdata,
  output logic                    host_rsp_valid,
  output logic [7:0]              host_rsp_rdata,
  output logic                    host_rsp_err,
  input  logic                    tx_valid,
  input  logic [7:0]              tx_data,
  output logic                    tx_ready,
  output logic                    init_done,
  output logic                    err_sticky
);

  // 16550 register indices (DLL/DLM alias THR/IER while LCR.DLAB=1)
  localparam logic [2:0] RegThr = 3'd0;
  localparam logic [2:0] RegDll = 3'd0;
  localparam logic [2:0] RegIer = 3'd1;
  localparam logic [2:0] RegDlm = 3'd1;
  localparam logic [2:0] RegFcr = 3'd2;
  localparam logic [2:0] RegLcr = 3'd3;
  localparam logic [2:0] RegLsr = 3'd5;
  localparam logic [2:0] InitLast = 3'd5;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t;
  typedef enum logic [1:0] {OWN_INIT, OWN_HOST, OWN_LSR, OWN_THR} owner_t;

  apb_state_t state;
  owner_t     owner;
  logic [2:0] init_idx;
  logic       rr_host;        // 1: host wins a tie, 0: TX wins a tie
  logic       thr_pending;    // LSR poll saw THRE, THR write goes next
  logic       host_is_write;

  logic [2:0] init_reg;
  logic [7:0] init_byte;

  logic       go;
  owner_t     go_owner;
  logic [2:0] go_reg;
  logic       go_write;
  logic [7:0] go_byte;

  logic       timeout;
  logic       xfer_done;
  logic       xfer_err;
  logic       lsr_thre;

  function automatic logic [AddressWidth-1:0] reg_addr(input logic [2:0] idx);
    return BaseAddr + AddressWidth'(idx) * AddressWidth'(RegStride);
  endfunction

  // Init write table: divisor latch opened via DLAB, then final LCR, FIFOs on, interrupts off
  always_comb begin
    init_reg  = RegLcr;
    init_byte = LcrValue | 8'h80;
    case (init_idx)
      3'd0: begin init_reg = RegLcr; init_byte = LcrValue | 8'h80; end
      3'd1: begin init_reg = RegDll; init_byte = Divisor[7:0];     end
      3'd2: begin init_reg = RegDlm; init_byte = Divisor[15:8];    end
      3'd3: begin init_reg = RegLcr; init_byte = LcrValue & 8'h7F; end
      3'd4: begin init_reg = RegFcr; init_byte = 8'h07;            end
      3'd5: begin init_reg = RegIer; init_byte = 8'h00;            end
      default: begin init_reg = RegIer; init_byte = 8'h00;         end
    endcase
  end

  // Pick the next transfer while idle: init first, then a pending THR write, then round-robin host/TX
  always_comb begin
    go       = 1'b0;
    go_owner = OWN_INIT;
    go_reg   = init_reg;
    go_write = 1'b1;
    go_byte  = init_byte;
    if (state == APB_IDLE) begin
      if (!init_done) begin
        go = 1'b1;
      end else if (thr_pending) begin
        go       = 1'b1;
        go_owner = OWN_THR;
        go_reg   = RegThr;
        go_byte  = tx_data;
      end else if (host_req_valid && (rr_host || !tx_valid)) begin
        go       = 1'b1;
        go_owner = OWN_HOST;
        go_reg   = host_req_reg;
        go_write = host_req_write;
        go_byte  = host_req_write ? host_req_wdata : 8'h00;
      end else if (tx_valid) begin
        go       = 1'b1;
        go_owner = OWN_LSR;
        go_reg   = RegLsr;
        go_write = 1'b0;
        go_byte  = 8'h00;
      end
    end
  end

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] wait_cnt;

  // Count ACCESS cycles spent without pready; cleared whenever ACCESS is left or pready arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == APB_ACCESS && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = (state == APB_ACCESS) && !pready &&
                   (wait_cnt == CntWidth'(TimeoutCycles - 1));
`else
  // Without the timeout build ACCESS simply waits for pready
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
`endif

  // Only the low byte of prdata carries UART register contents
  logic unused_prdata;
  assign unused_prdata = ^prdata[DataWidth-1:8];

  assign xfer_done = (state == APB_ACCESS) && (pready || timeout);
  assign xfer_err  = (penable && pready && pslverr) || timeout;
  assign lsr_thre  = pready && !pslverr && prdata[5];

  // APB master FSM with all bus and handshake outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= APB_IDLE;
      owner          <= OWN_INIT;
      init_idx       <= 3'd0;
      rr_host        <= 1'b1;
      thr_pending    <= 1'b0;
      host_is_write  <= 1'b0;
      paddr          <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      host_req_ready <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_rdata <= 8'h00;
      host_rsp_err   <= 1'b0;
      tx_ready       <= 1'b0;
      init_done      <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      host_req_ready <= 1'b0;
      host_rsp_valid <= 1'b0;
      tx_ready       <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (go) begin
            state   <= APB_SETUP;
            owner   <= go_owner;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= go_write;
            paddr   <= reg_addr(go_reg);
            pwdata  <= {{(DataWidth-8){1'b0}}, go_byte};
            if (go_owner == OWN_HOST) begin
              host_req_ready <= 1'b1;
              host_is_write  <= host_req_write;
              rr_host        <= 1'b0;
            end
            if (go_owner == OWN_LSR) begin
              rr_host <= 1'b1;
            end
          end
        end
        APB_SETUP: begin
          penable <= 1'b1;
          state   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (xfer_done) begin
            state   <= APB_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            if (xfer_err) begin
              err_sticky <= 1'b1;
            end
            case (owner)
              OWN_INIT: begin
                if (init_idx == InitLast) begin
                  init_done <= 1'b1;
                end else begin
                  init_idx <= init_idx + 3'd1;
                end
              end
              OWN_HOST: begin
                host_rsp_valid <= 1'b1;
                host_rsp_err   <= xfer_err;
                host_rsp_rdata <= (host_is_write || timeout) ? 8'h00 : prdata[7:0];
              end
              OWN_LSR: begin
                thr_pending <= lsr_thre;
              end
              OWN_THR: begin
                thr_pending <= 1'b0;
                tx_ready    <= !timeout;
              end
              default: begin
                thr_pending <= 1'b0;
              end
            endcase
          end
        end
        default: begin
          state   <= APB_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: directed bench with a scripted APB slave and a transfer log.
// Latency: slave answers after cfg_wait ACCESS cycles; checks sample 1ns after the falling edge.
// Backpressure: pready held low for cfg_wait cycles per transfer.
`timescale 1ns/1ps
module tb_uart_apb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_write;
  logic [2:0]  host_req_reg;
  logic [7:0]  host_req_wdata;
  logic        host_rsp_valid;
  logic [7:0]  host_rsp_rdata;
  logic        host_rsp_err;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        init_done;
  logic        err_sticky;

  uart_apb_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .paddr          (paddr),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_req_write (host_req_write),
    .host_req_reg   (host_req_reg),
    .host_req_wdata (host_req_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_rdata (host_rsp_rdata),
    .host_rsp_err   (host_rsp_err),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .init_done      (init_done),
    .err_sticky     (err_sticky)
  );

  always #5 clk = ~clk;

  // slave configuration and observation state
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  logic [7:0]  lsr_q[$];
  int          slv_wait = 0;
  logic [31:0] log_addr[64];
  logic        log_wr[64];
  logic [31:0] log_dat[64];
  int          n_log = 0;
  int          psel_cycles = 0;
  int          n_rdy = 0;
  int          n_rsp = 0;
  int          n_txr = 0;
  logic [7:0]  last_rsp_rdata = 8'h00;
  logic        last_rsp_err = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // scripted APB slave and event counters, all on the falling edge
  initial begin : slave
    forever begin
      @(negedge clk);
      if (psel) psel_cycles++;
      if (host_req_ready) n_rdy++;
      if (host_rsp_valid) begin
        n_rsp++;
        last_rsp_rdata = host_rsp_rdata;
        last_rsp_err   = host_rsp_err;
      end
      if (tx_ready) n_txr++;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      if (rst_n && psel && penable) begin
        if (slv_wait < cfg_wait) begin
          slv_wait++;
        end else begin
          pready  = 1'b1;
          pslverr = cfg_err;
          if (!pwrite) begin
            if (paddr == 32'h14) begin
              if (lsr_q.size() > 0) prdata = {24'h0, lsr_q.pop_front()};
              else prdata = 32'h60;
            end else begin
              prdata = {24'h0, rd_val};
            end
          end
          if (n_log < 64) begin
            log_addr[n_log] = paddr;
            log_wr[n_log]   = pwrite;
            log_dat[n_log]  = pwdata;
          end
          n_log++;
          slv_wait = 0;
        end
      end else begin
        slv_wait = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_xfer(input int idx, input logic wr, input logic [31:0] addr,
                            input logic [31:0] dat, input string tag);
    check(tag, {7'd0, log_wr[idx], log_addr[idx], log_dat[idx]}, {7'd0, wr, addr, dat});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (n_log < n && k < 300) begin
      tick();
      k++;
    end
    check(tag, 72'(n_log >= n), 72'd1);
  endtask

  task automatic wait_rsp(input int r0, input string tag);
    int k = 0;
    while (n_rsp == r0 && k < 200) begin
      tick();
      k++;
    end
    check(tag, 72'(n_rsp != r0), 72'd1);
  endtask

  task automatic host_req(input logic wr, input logic [2:0] r, input logic [7:0] d,
                          input string tag);
    int k = 0;
    host_req_valid = 1'b1;
    host_req_write = wr;
    host_req_reg   = r;
    host_req_wdata = d;
    while (!host_req_ready && k < 200) begin
      tick();
      k++;
    end
    check(tag, 72'(host_req_ready), 72'd1);
    host_req_valid = 1'b0;
  endtask

  initial begin : stim
    int k;
    int base;
    int p0;
    int r0;
    rst_n = 1'b0;
    host_req_valid = 1'b0;
    host_req_write = 1'b0;
    host_req_reg   = 3'd0;
    host_req_wdata = 8'h00;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // reset state
    #12;
    check("rst_ctrl", 72'({psel, penable, pwrite, host_req_ready, host_rsp_valid,
                           host_rsp_err, tx_ready, init_done, err_sticky}), 72'd0);
    check("rst_paddr", 72'(paddr), 72'd0);
    check("rst_data", 72'({pwdata, host_rsp_rdata}), 72'd0);
    tick();
    rst_n = 1'b1;

    // init sequence
    wait_log(6, "init_wait");
    check("init_done_early", 72'(init_done), 72'd0);
    tick();
    check("init_done_rise", 72'(init_done), 72'd1);
    check_xfer(0, 1'b1, 32'h0C, 32'h83, "init_lcr_dlab");
    check_xfer(1, 1'b1, 32'h00, 32'h0A, "init_dll");
    check_xfer(2, 1'b1, 32'h04, 32'h00, "init_dlm");
    check_xfer(3, 1'b1, 32'h0C, 32'h03, "init_lcr");
    check_xfer(4, 1'b1, 32'h08, 32'h07, "init_fcr");
    check_xfer(5, 1'b1, 32'h04, 32'h00, "init_ier");
    check("init_psel_cycles", 72'(psel_cycles), 72'd12);
    check("init_no_handshakes", 72'(n_rdy + n_txr + n_rsp), 72'd0);
    check("init_no_err", 72'(err_sticky), 72'd0);

    // TX byte with THRE set on first poll
    lsr_q.push_back(8'h60);
    tx_data  = 8'h41;
    tx_valid = 1'b1;
    wait_log(8, "tx1_wait");
    k = 0;
    while (!tx_ready && k < 20) begin
      tick();
      k++;
    end
    check("tx1_ready", 72'(tx_ready), 72'd1);
    tx_valid = 1'b0;
    repeat (6) tick();
    check_xfer(6, 1'b0, 32'h14, 32'h00, "tx1_lsr_read");
    check_xfer(7, 1'b1, 32'h00, 32'h41, "tx1_thr_write");
    check("tx1_one_pulse", 72'(n_txr), 72'd1);
    check("tx1_no_extra", 72'(n_log), 72'd8);

    // TX polling with host write arriving while the first poll is on the bus
    lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h20);
    tx_data  = 8'h42;
    tx_valid = 1'b1;
    k = 0;
    while (!psel && k < 20) begin
      tick();
      k++;
    end
    check("tx2_first_poll", 72'(psel), 72'd1);
    r0 = n_rsp;
    host_req(1'b1, 3'd7, 8'h5A, "tx2_host_ready");
    k = 0;
    while (!tx_ready && k < 100) begin
      tick();
      k++;
    end
    check("tx2_ready", 72'(tx_ready), 72'd1);
    tx_valid = 1'b0;
    repeat (6) tick();
    check_xfer(8,  1'b0, 32'h14, 32'h00, "tx2_lsr1");
    check_xfer(9,  1'b1, 32'h1C, 32'h5A, "tx2_scr_write");
    check_xfer(10, 1'b0, 32'h14, 32'h00, "tx2_lsr2");
    check_xfer(11, 1'b0, 32'h14, 32'h00, "tx2_lsr3");
    check_xfer(12, 1'b1, 32'h00, 32'h42, "tx2_thr_write");
    check("tx2_log_count", 72'(n_log), 72'd13);
    check("tx2_tx_pulses", 72'(n_txr), 72'd2);
    check("tx2_host_rsp", 72'({n_rsp - r0, 7'd0, last_rsp_err, last_rsp_rdata}),
          72'({32'd1, 16'h0000}));

    // host read with pready held low for 3 cycles
    cfg_wait = 3;
    rd_val   = 8'h5A;
    p0 = psel_cycles;
    r0 = n_rsp;
    host_req(1'b0, 3'd7, 8'h00, "rd_ready");
    wait_rsp(r0, "rd_rsp_wait");
    check("rd_rdata", 72'(last_rsp_rdata), 72'h5A);
    check("rd_err", 72'(last_rsp_err), 72'd0);
    check("rd_psel_cycles", 72'(psel_cycles - p0), 72'd5);
    check_xfer(13, 1'b0, 32'h1C, 32'h00, "rd_xfer");
    repeat (3) tick();
    check("rd_one_rsp", 72'(n_rsp - r0), 72'd1);
    cfg_wait = 0;

    // host write with slave error, then clean read
    check("err_clear_before", 72'(err_sticky), 72'd0);
    cfg_err = 1'b1;
    r0 = n_rsp;
    host_req(1'b1, 3'd1, 8'h11, "werr_ready");
    wait_rsp(r0, "werr_rsp_wait");
    check("werr_rsp", 72'({last_rsp_err, last_rsp_rdata}), 72'h100);
    check("werr_sticky", 72'(err_sticky), 72'd1);
    check_xfer(14, 1'b1, 32'h04, 32'h11, "werr_xfer");
    cfg_err = 1'b0;
    rd_val  = 8'h33;
    r0 = n_rsp;
    host_req(1'b0, 3'd2, 8'h00, "rd2_ready");
    wait_rsp(r0, "rd2_rsp_wait");
    check("rd2_rsp", 72'({last_rsp_err, last_rsp_rdata}), 72'h033);
    check("rd2_sticky_held", 72'(err_sticky), 72'd1);
    check_xfer(15, 1'b0, 32'h08, 32'h00, "rd2_xfer");

    // reset during ACCESS of the third init write
    cfg_wait = 4;
    rst_n = 1'b0;
    #1;
    check("rst2_clears", 72'({init_done, err_sticky, psel}), 72'd0);
    tick();
    rst_n = 1'b1;
    base = n_log;
    k = 0;
    while (!(psel && penable && paddr == 32'h04) && k < 100) begin
      tick();
      k++;
    end
    check("rst3_in_dlm_access", 72'({psel, penable, paddr}), 72'({2'b11, 32'h04}));
    check("rst3_prior_writes", 72'(n_log - base), 72'd2);
    rst_n = 1'b0;
    #1;
    check("rst3_bus_drop", 72'({psel, penable}), 72'd0);
    tick();
    cfg_wait = 0;
    tick();
    rst_n = 1'b1;
    base = n_log;
    wait_log(base + 6, "reinit_wait");
    tick();
    check("reinit_done", 72'(init_done), 72'd1);
    check_xfer(base,     1'b1, 32'h0C, 32'h83, "reinit_first");
    check_xfer(base + 2, 1'b1, 32'h04, 32'h00, "reinit_dlm");
    check_xfer(base + 5, 1'b1, 32'h04, 32'h00, "reinit_last");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
